// File: rtl/forward_scoreboard.sv
// Forwarding and hazard unit for the EX stage.
// A DEPTH-slot shift register mirrors the post-EX pipeline registers. Each slot
// remembers which register the instruction in that pipeline register will
// write, and how many more shifts it needs before its result is valid.
// Each EX source operand takes the youngest matching slot if that slot is ready.
// If the youngest matching slot is not ready, the source is blocked and a hazard
// is raised. An older ready copy is never used, because it holds a stale value.
//
// Timing contract: every output except hazard_cnt is purely combinational
// from the current inputs and slot state. While hazard is high, the EX
// instruction is held: it is not entered into slot 0, a bubble goes in instead,
// and it is presented again next cycle. freeze stalls the whole tracker.
module forward_scoreboard #(
  parameter int W       = 32,
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int LAT_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic                    ex_wr_en,
  input  logic [RA_W-1:0]         ex_wr_addr,
  input  logic [LAT_W-1:0]        ex_lat,
  input  logic [NUM_SRC-1:0]      ex_rd_en,
  input  logic [NUM_SRC*RA_W-1:0] ex_rd_addr,
  input  logic [NUM_SRC*W-1:0]    rf_val,
  input  logic [DEPTH*W-1:0]      slot_data,
  input  logic                    freeze,
  output logic [NUM_SRC*W-1:0]    fwd_val,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic                    hazard,
  output logic [31:0]             hazard_cnt
);

  localparam int MAX_LAT = DEPTH - 1;

  logic [DEPTH-1:0] e_valid;
  logic [RA_W-1:0]  e_addr [DEPTH];
  logic [LAT_W-1:0] e_cnt  [DEPTH];

  logic [LAT_W-1:0]   lat_clip;
  logic [NUM_SRC-1:0] blocked;

  // Clip the latency so that every entry is ready by the last slot.
  always_comb begin
    lat_clip = ex_lat;
    if (int'(ex_lat) > MAX_LAT) lat_clip = LAT_W'(MAX_LAT);
  end

  // Operand select. Slots are scanned from oldest to youngest, so the youngest
  // match is written last and overrides any older one.
  always_comb begin
    fwd_val = rf_val;
    fwd_hit = '0;
    blocked = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ex_rd_en[i] && (ex_rd_addr[i*RA_W +: RA_W] != '0) && e_valid[k] &&
            (e_addr[k] == ex_rd_addr[i*RA_W +: RA_W])) begin
          if (e_cnt[k] == '0) begin
            fwd_hit[i]          = 1'b1;
            blocked[i]          = 1'b0;
            fwd_val[i*W +: W]   = slot_data[k*W +: W];
          end else begin
            fwd_hit[i]          = 1'b0;
            blocked[i]          = 1'b1;
            fwd_val[i*W +: W]   = rf_val[i*W +: W];
          end
        end
      end
    end
  end

  // Stall request. This is suppressed while the whole pipeline is frozen.
  always_comb begin
    hazard = ex_valid & (|blocked) & ~freeze;
  end

  // Slot shift register. Entries age by one slot per unfrozen edge, and slot 0
  // takes either the EX write or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        e_addr[k] <= '0;
        e_cnt[k]  <= '0;
      end
    end else if (!freeze) begin
      for (int k = 1; k < DEPTH; k++) begin
        e_valid[k] <= e_valid[k-1];
        e_addr[k]  <= e_addr[k-1];
        e_cnt[k]   <= (e_cnt[k-1] == '0) ? '0 : e_cnt[k-1] - LAT_W'(1);
      end
      if (hazard) begin
        e_valid[0] <= 1'b0;
        e_addr[0]  <= '0;
        e_cnt[0]   <= '0;
      end else begin
        e_valid[0] <= ex_valid & ex_wr_en & (ex_wr_addr != '0);
        e_addr[0]  <= ex_wr_addr;
        e_cnt[0]   <= lat_clip;
      end
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_cnt <= '0;
    end else if (hazard && (hazard_cnt != 32'hFFFF_FFFF)) begin
      hazard_cnt <= hazard_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard.
// The reference model tracks each in-flight write by its position in the
// pipeline and by the slot at which its result becomes valid. An entry is
// ready once its position has reached its latency.
// A negedge process compares every DUT output against the model on each cycle.
// Directed scenarios add hand-computed literal checks on top of the model.
module tb_forward_scoreboard;

  localparam int W    = 32;
  localparam int RA_W = 5;
  localparam int NS   = 2;
  localparam int D    = 3;
  localparam int LW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ex_valid;
  logic              ex_wr_en;
  logic [RA_W-1:0]   ex_wr_addr;
  logic [LW-1:0]     ex_lat;
  logic [NS-1:0]     ex_rd_en;
  logic [NS*RA_W-1:0] ex_rd_addr;
  logic [NS*W-1:0]   rf_val;
  logic [D*W-1:0]    slot_data;
  logic              freeze;
  logic [NS*W-1:0]   fwd_val;
  logic [NS-1:0]     fwd_hit;
  logic              hazard;
  logic [31:0]       hazard_cnt;

  int vectors = 0;
  int miscompares = 0;

  forward_scoreboard #(.W(W), .RA_W(RA_W), .NUM_SRC(NS), .DEPTH(D), .LAT_W(LW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wr_en(ex_wr_en),
    .ex_wr_addr(ex_wr_addr), .ex_lat(ex_lat), .ex_rd_en(ex_rd_en),
    .ex_rd_addr(ex_rd_addr), .rf_val(rf_val), .slot_data(slot_data),
    .freeze(freeze), .fwd_val(fwd_val), .fwd_hit(fwd_hit), .hazard(hazard),
    .hazard_cnt(hazard_cnt)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position k is the pipeline register k after EX. m_lat is the position at
  // which that write's result exists.
  logic        m_v   [D];
  logic [RA_W-1:0] m_a [D];
  int          m_lat [D];
  logic [31:0] m_cnt;
  logic        p_v   [D];
  logic [RA_W-1:0] p_a [D];
  int          p_lat [D];
  logic [31:0] p_cnt;

  function automatic void model_eval(output logic [NS*W-1:0] ev,
                                     output logic [NS-1:0] eh,
                                     output logic ez);
    logic [NS-1:0]   blk;
    logic [RA_W-1:0] a;
    logic            found;
    ev  = rf_val;
    eh  = '0;
    blk = '0;
    for (int i = 0; i < NS; i++) begin
      a = ex_rd_addr[i*RA_W +: RA_W];
      found = 1'b0;
      if (ex_rd_en[i] && a != '0) begin
        for (int k = 0; k < D; k++) begin
          if (!found && m_v[k] && m_a[k] == a) begin
            found = 1'b1;
            if (k >= m_lat[k]) begin
              eh[i] = 1'b1;
              ev[i*W +: W] = slot_data[k*W +: W];
            end else begin
              blk[i] = 1'b1;
            end
          end
        end
      end
    end
    ez = ex_valid && (blk != '0) && !freeze;
  endfunction

  // Compare process: check outputs mid-cycle and compute the model's next state
  always @(negedge clk) begin
    logic [NS*W-1:0] ev;
    logic [NS-1:0]   eh;
    logic            ez;
    model_eval(ev, eh, ez);
    for (int i = 0; i < NS; i++) chk("model_fwd_val", fwd_val[i*W +: W], ev[i*W +: W]);
    chk("model_fwd_hit", 32'(fwd_hit), 32'(eh));
    chk("model_hazard", 32'(hazard), 32'(ez));
    chk("model_hazard_cnt", hazard_cnt, m_cnt);
    if (freeze) begin
      for (int k = 0; k < D; k++) begin
        p_v[k] = m_v[k]; p_a[k] = m_a[k]; p_lat[k] = m_lat[k];
      end
      p_cnt = m_cnt;
    end else begin
      for (int k = 1; k < D; k++) begin
        p_v[k] = m_v[k-1]; p_a[k] = m_a[k-1]; p_lat[k] = m_lat[k-1];
      end
      if (ez) begin
        p_v[0] = 1'b0; p_a[0] = '0; p_lat[0] = 0;
      end else begin
        p_v[0]   = ex_valid && ex_wr_en && ex_wr_addr != '0;
        p_a[0]   = ex_wr_addr;
        p_lat[0] = (int'(ex_lat) > D - 1) ? D - 1 : int'(ex_lat);
      end
      p_cnt = (ez && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
    end
  end

  // Model state register
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        m_v[k] <= 1'b0; m_a[k] <= '0; m_lat[k] <= 0;
      end
      m_cnt <= '0;
    end else begin
      for (int k = 0; k < D; k++) begin
        m_v[k] <= p_v[k]; m_a[k] <= p_a[k]; m_lat[k] <= p_lat[k];
      end
      m_cnt <= p_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic we, input logic [RA_W-1:0] wa,
                       input logic [LW-1:0] lat, input logic [NS-1:0] re,
                       input logic [RA_W-1:0] a0, input logic [RA_W-1:0] a1);
    ex_valid   = v;
    ex_wr_en   = we;
    ex_wr_addr = wa;
    ex_lat     = lat;
    ex_rd_en   = re;
    ex_rd_addr = {a1, a0};
  endtask

  task automatic flush();
    issue(1'b0, 1'b0, '0, '0, '0, '0, '0);
    repeat (D) tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    issue(1'b0, 1'b0, '0, '0, '0, '0, '0);
    rf_val    = {32'h0000_B0B1, 32'h0000_A0A1};
    slot_data = {32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};
    freeze    = 1'b0;
    rst       = 1'b1;
    repeat (2) tick();
    chk("rst_hazard_cnt", hazard_cnt, 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    chk("rst_fwd_val0", fwd_val[31:0], 32'h0000_A0A1);
    chk("rst_fwd_val1", fwd_val[63:32], 32'h0000_B0B1);
    chk("rst_hazard", 32'(hazard), 32'd0);
    rst = 1'b0;
    tick();

    // ALU chain: r5 lat 0 forwarded from slot 0
    issue(1'b1, 1'b1, 5'd5, 2'd0, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd5, '0);
    slot_data[31:0] = 32'h0000_1234;
    #1;
    chk("alu_hit", 32'(fwd_hit), 32'd1);
    chk("alu_val0", fwd_val[31:0], 32'h0000_1234);
    chk("alu_val1", fwd_val[63:32], 32'h0000_B0B1);
    chk("alu_hazard", 32'(hazard), 32'd0);
    tick();
    flush();

    // Load-use: one stall cycle, then forward from slot 1
    issue(1'b1, 1'b1, 5'd3, 2'd1, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd3, '0);
    slot_data[63:32] = 32'h0000_BEEF;
    #1;
    chk("lu_hazard", 32'(hazard), 32'd1);
    tick();
    chk("lu_hazard_after", 32'(hazard), 32'd0);
    chk("lu_hit", 32'(fwd_hit), 32'd1);
    chk("lu_val0", fwd_val[31:0], 32'h0000_BEEF);
    chk("lu_cnt", hazard_cnt, 32'd1);
    tick();
    flush();

    // Youngest wins: r7 in slot 0 and slot 1, both ready
    slot_data = {32'h0000_0000, 32'h0000_5555, 32'h0000_AAAA};
    issue(1'b1, 1'b1, 5'd7, 2'd0, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b1, 5'd7, 2'd0, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b10, '0, 5'd7);
    #1;
    chk("yw_val1", fwd_val[63:32], 32'h0000_AAAA);
    chk("yw_hit", 32'(fwd_hit), 32'd2);
    chk("yw_hazard", 32'(hazard), 32'd0);
    tick();
    flush();
    // Slot 0 not ready: stall even though slot 1 holds a ready older copy
    issue(1'b1, 1'b1, 5'd7, 2'd0, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b1, 5'd7, 2'd1, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b10, '0, 5'd7);
    #1;
    chk("yw_stall_hazard", 32'(hazard), 32'd1);
    chk("yw_stall_hit", 32'(fwd_hit), 32'd0);
    tick();
    chk("yw_res_hazard", 32'(hazard), 32'd0);
    chk("yw_res_val1", fwd_val[63:32], 32'h0000_5555);
    chk("yw_res_cnt", hazard_cnt, 32'd2);
    tick();
    flush();

    // r0 is never forwarded
    issue(1'b1, 1'b1, 5'd0, 2'd0, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd0, '0);
    slot_data = {3{32'hFFFF_FFFF}};
    rf_val[31:0] = 32'h0;
    #1;
    chk("r0_hit", 32'(fwd_hit), 32'd0);
    chk("r0_val0", fwd_val[31:0], 32'h0);
    chk("r0_hazard", 32'(hazard), 32'd0);
    tick();
    flush();
    rf_val = {32'h0000_B0B1, 32'h0000_A0A1};

    // Freeze during a lat-2 stall
    slot_data = {32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
    issue(1'b1, 1'b1, 5'd9, 2'd2, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd9, '0);
    #1;
    chk("frz_pre_hazard", 32'(hazard), 32'd1);
    freeze = 1'b1;
    #1;
    chk("frz_hazard", 32'(hazard), 32'd0);
    repeat (3) begin
      tick();
      chk("frz_cnt", hazard_cnt, 32'd2);
    end
    freeze = 1'b0;
    #1;
    chk("frz_rel_hazard", 32'(hazard), 32'd1);
    tick();
    chk("frz_h2", 32'(hazard), 32'd1);
    chk("frz_cnt3", hazard_cnt, 32'd3);
    tick();
    chk("frz_done_hazard", 32'(hazard), 32'd0);
    chk("frz_val0", fwd_val[31:0], 32'h0000_3333);
    chk("frz_cnt4", hazard_cnt, 32'd4);
    tick();
    flush();

    // Latency 3 clips to 2: two stall cycles, forward from slot 2
    issue(1'b1, 1'b1, 5'd10, 2'd3, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd10, '0);
    #1;
    chk("clip_h1", 32'(hazard), 32'd1);
    tick();
    chk("clip_h2", 32'(hazard), 32'd1);
    tick();
    chk("clip_h3", 32'(hazard), 32'd0);
    chk("clip_val0", fwd_val[31:0], 32'h0000_3333);
    chk("clip_cnt", hazard_cnt, 32'd6);
    tick();
    flush();

    // Asynchronous reset while stalled
    issue(1'b1, 1'b1, 5'd11, 2'd1, 2'b00, '0, '0);
    tick();
    issue(1'b1, 1'b0, '0, 2'd0, 2'b01, 5'd11, '0);
    #1;
    chk("ar_pre_hazard", 32'(hazard), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_hazard", 32'(hazard), 32'd0);
    chk("ar_cnt", hazard_cnt, 32'd0);
    chk("ar_hit", 32'(fwd_hit), 32'd0);
    chk("ar_val0", fwd_val[31:0], 32'h0000_A0A1);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after_hazard", 32'(hazard), 32'd0);
    chk("ar_after_hit", 32'(fwd_hit), 32'd0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
